program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time controller that sequences the single-cycle RISC-V core.
- Holds the core in reset while a program image arrives byte-by-byte from the UART receiver.
- Assembles the bytes into 32-bit words, writes them into instruction memory, and acknowledges the host over the UART transmitter.
- Releases the core reset once the image is complete, so the core starts fetching at word address 0.

Parameters:
ADDR_WIDTH, 12, instruction-memory word-address width; capacity = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_valid  input  1  single-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
tx_valid  output  1  byte on tx_data offered to UART transmitter
tx_data  output  8  byte to transmit
tx_ready  input  1  transmitter accepts tx_data on an edge where tx_valid && tx_ready
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  instruction-memory word address
imem_wdata  output  32  instruction-memory write data
core_rst  output  1  reset to core, high while loading
busy  output  1  image transfer in progress
done  output  1  core released and running
err  output  1  load rejected, sticky until rst

Behaviour:
- All outputs registered. On reset:
  - state=S_LEN; byte_cnt=0; word_cnt=0.
  - core_rst=1; tx_valid=0; tx_data=0; imem_we=0; imem_addr=0; imem_wdata=0; busy=0; done=0; err=0.
- Protocol: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (byte 0 = bits 7:0).
- rx_data is sampled only on edges with rx_valid=1. There is no backpressure. rx bytes in S_ACK, S_NAK, S_RUN and S_ERR are ignored.
- byte_cnt (2 bits) counts bytes of the current field. Bytes shift into a 32-bit assembly register; byte_cnt wraps 3->0 on the 4th byte.
- S_LEN, on the 4th length byte:
  - N=0: go to S_ACK.
  - N>2**ADDR_WIDTH: go to S_NAK.
  - Otherwise: latch N and go to S_DATA. busy=1 from this edge.
- S_DATA, on the edge sampling the 4th byte of word k:
  - Next cycle: imem_we=1 for exactly one cycle, imem_addr=k, imem_wdata=assembled word.
  - word_cnt increments.
  - If k=N-1, go to S_ACK at the same edge.
- S_ACK:
  - tx_valid=1 and tx_data=0xAA are asserted at the entry edge.
  - Both hold, stable, until an edge with tx_ready=1. At that edge: tx_valid=0, core_rst=0, busy=0, done=1, go to S_RUN.
- S_NAK: same handshake with tx_data=0xEE. On acceptance go to S_ERR with err=1; core_rst stays 1.
- S_RUN and S_ERR are terminal until rst.
- Simultaneous events:
  - The last word's imem_we and the ACK's tx_valid rise in the same cycle.
  - tx_ready high while tx_valid=0 is ignored.
- Mid-operation rst:
  - Partial word is discarded and all counters cleared.
  - core_rst=1, busy/done/err=0.
  - tx_valid drops at the reset edge, even mid-handshake.
- Maximum legal image is N=2**ADDR_WIDTH. Its last address is 2**ADDR_WIDTH-1; imem_addr never wraps.

Test Plan:
1. ADDR_WIDTH=4. Send 02 00 00 00, 13 00 00 00, 93 00 10 00 -> imem writes (0,0x00000013), (1,0x00100093), one cycle each. tx_valid=1, tx_data=0xAA; after tx_ready, core_rst=0 and done=1.
2. Send 00 00 00 00 -> no imem_we. Immediate 0xAA. Core released after handshake.
3. ADDR_WIDTH=4. Send 11 00 00 00 (N=17) -> tx_data=0xEE; after handshake err=1, core_rst stays 1. Further bytes cause no imem_we.
4. N=16, 64 data bytes with rx_valid gaps of 0-5 cycles -> 16 writes to addresses 0..15, no wrap.
5. Hold tx_ready=0 for 10 cycles during ACK -> tx_valid/tx_data stable and core_rst=1. Release when tx_ready=1.
6. Assert rst after 2 bytes of word 1 -> all outputs at reset values. A subsequent full image for N=1 loads word 0 correctly.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Boot-time sequencer for the single-cycle RISC-V core. The core is held in
//   reset while a program image streams in over the UART receiver. Bytes are
//   packed into little-endian 32-bit words and written to instruction memory.
//   The host gets an ACK (0xAA) or a NAK (0xEE) over the UART transmitter.
//   After an accepted ACK the core reset is released.
//
//   Image format: 4-byte little-endian word count N, then N words of 4 bytes
//   each, also little-endian.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   tx_valid   tx_data is offered to the transmitter
//   tx_data    response byte (0xAA ack / 0xEE nak)
//   tx_ready   transmitter takes tx_data when tx_valid && tx_ready
//   imem_we    one-cycle instruction-memory write strobe
//   imem_addr  instruction-memory word address
//   imem_wdata instruction-memory write data
//   core_rst   core reset, high until the image is accepted
//   busy       image words are being received
//   done       core released and running
//   err        image rejected, sticky until rst
//
// state  | meaning
// S_LEN  | collecting the 4-byte word count
// S_DATA | collecting image words, one imem write per word
// S_ACK  | offering 0xAA, waiting for the transmitter
// S_NAK  | offering 0xEE, waiting for the transmitter
// S_RUN  | core released (terminal)
// S_ERR  | load rejected (terminal)

module program_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_ACK,
    S_NAK,
    S_RUN,
    S_ERR
  } state_t;

  // Word counters need one extra bit so a full image (2**ADDR_WIDTH words)
  // is representable.
  localparam int          CW       = ADDR_WIDTH + 1;
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;
  localparam logic [7:0]  ACK_BYTE = 8'hAA;
  localparam logic [7:0]  NAK_BYTE = 8'hEE;

  state_t                  state, state_d;
  logic [1:0]              byte_cnt, byte_cnt_d;
  logic [CW-1:0]           word_cnt, word_cnt_d;
  logic [CW-1:0]           n_words, n_words_d;
  // Holds the three most recent bytes of the current field; the fourth byte
  // is combined directly from rx_data when it arrives.
  logic [23:0]             asm_reg, asm_reg_d;
  logic [31:0]             word_next;

  logic                    tx_valid_d;
  logic [7:0]              tx_data_d;
  logic                    imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_d;
  logic [31:0]             imem_wdata_d;
  logic                    core_rst_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    err_d;

  assign word_next = {rx_data, asm_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      n_words    <= '0;
      asm_reg    <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      byte_cnt   <= byte_cnt_d;
      word_cnt   <= word_cnt_d;
      n_words    <= n_words_d;
      asm_reg    <= asm_reg_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      core_rst   <= core_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d      = state;
    byte_cnt_d   = byte_cnt;
    word_cnt_d   = word_cnt;
    n_words_d    = n_words;
    asm_reg_d    = asm_reg;
    tx_valid_d   = tx_valid;
    tx_data_d    = tx_data;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    core_rst_d   = core_rst;
    busy_d       = busy;
    done_d       = done;
    err_d        = err;

    case (state)
      S_LEN: begin
        if (rx_valid) begin
          asm_reg_d  = word_next[31:8];
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (word_next == 32'd0) begin
              state_d    = S_ACK;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK_BYTE;
            end else if ({1'b0, word_next} > CAPACITY) begin
              state_d    = S_NAK;
              tx_valid_d = 1'b1;
              tx_data_d  = NAK_BYTE;
            end else begin
              state_d   = S_DATA;
              n_words_d = word_next[CW-1:0];
              busy_d    = 1'b1;
            end
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          asm_reg_d  = word_next[31:8];
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt[ADDR_WIDTH-1:0];
            imem_wdata_d = word_next;
            word_cnt_d   = word_cnt + CW'(1);
            // Last word: the ACK goes out alongside the final write.
            if (word_cnt + CW'(1) == n_words) begin
              state_d    = S_ACK;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK_BYTE;
            end
          end
        end
      end

      S_ACK: begin
        if (tx_ready) begin
          state_d    = S_RUN;
          tx_valid_d = 1'b0;
          core_rst_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end

      S_NAK: begin
        if (tx_ready) begin
          state_d    = S_ERR;
          tx_valid_d = 1'b0;
          err_d      = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int AW = 4;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         obs[$];
  logic [31:0] img[$];
  int          txv_rise_cyc = -1;
  logic        txv_prev = 1'b0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) obs.push_back('{int'(imem_addr), imem_wdata, cyc});
    if (tx_valid === 1'b1 && txv_prev !== 1'b1) txv_rise_cyc = cyc;
    txv_prev = tx_valid;
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({core_rst, tx_valid, tx_data, imem_we, imem_addr, imem_wdata, busy, done, err}),
          64'(1) << 49);
    rst = 1'b0;
    @(posedge clk);
    obs.delete();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rand_gap(input int gapmax, output int g);
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
  endtask

  // Reference: a valid count (1..CAP) yields writes (k, img[k]) and an ACK;
  // N=0 yields no writes and an ACK; N>CAP yields no writes and a NAK.
  task automatic load_image(input logic [31:0] n, input int gapmax, input int hold);
    bit          ok;
    bit          ack;
    bit          stable;
    int          g;
    logic [7:0]  resp;
    logic [31:0] w;
    wr_t         exp[$];
    ok   = (n != 0) && (n <= 32'(CAP));
    ack  = (n <= 32'(CAP));
    resp = ack ? 8'hAA : 8'hEE;
    for (int i = 0; i < 4; i++) begin
      rand_gap(gapmax, g);
      send_byte(n[8*i +: 8], (i == 3) ? 0 : g);
    end
    check("busy_after_len", 64'(busy), 64'(ok));
    if (!ok) check("resp_immediate", 64'(tx_valid), 64'(1));
    if (ok) begin
      for (int k = 0; k < int'(n); k++) begin
        w = img[k];
        exp.push_back('{k, w, 0});
        for (int i = 0; i < 4; i++) begin
          rand_gap(gapmax, g);
          send_byte(w[8*i +: 8], (k == int'(n) - 1 && i == 3) ? 0 : g);
        end
      end
    end
    for (int t = 0; t < 300 && tx_valid !== 1'b1; t++) @(negedge clk);
    check("tx_valid_up", 64'(tx_valid), 64'(1));
    check("tx_data", 64'(tx_data), 64'(resp));
    check("core_rst_held", 64'(core_rst), 64'(1));
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== resp || core_rst !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", 64'(stable), 64'(1));
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("post_handshake", 64'({tx_valid, core_rst, busy, done, err}),
          ack ? 64'(5'b00010) : 64'(5'b01001));
    check("write_count", 64'(obs.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      check("write_addr", 64'(obs[i].addr), 64'(exp[i].addr));
      check("write_data", 64'(obs[i].data), 64'(exp[i].data));
    end
    if (ok && obs.size() > 0) check("we_with_tx_valid", 64'(obs[obs.size()-1].cyc), 64'(txv_rise_cyc));
    repeat (6) send_byte(8'($urandom), 0);
    check("no_write_after", 64'(obs.size()), 64'(exp.size()));
    check("terminal_hold", 64'({tx_valid, core_rst, busy, done, err}),
          ack ? 64'(5'b00010) : 64'(5'b01001));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int          n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    do_reset();

    // tx_ready with nothing offered changes nothing
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    tx_ready = 1'b0;
    check("ready_ignored", 64'({tx_valid, core_rst, busy, done, err}), 64'(5'b01000));

    // two-word directed image
    img = '{32'h0000_0013, 32'h0010_0093};
    load_image(32'd2, 0, 0);

    // empty image
    do_reset();
    img.delete();
    load_image(32'd0, 0, 0);

    // oversize counts
    do_reset();
    load_image(32'd17, 0, 0);
    do_reset();
    load_image(32'hFFFF_FFFF, 1, 0);

    // full-capacity image with gaps
    do_reset();
    img.delete();
    for (int k = 0; k < CAP; k++) img.push_back($urandom);
    load_image(32'(CAP), 5, 0);

    // transmitter stalls for 10 cycles during ACK
    do_reset();
    img.delete();
    for (int k = 0; k < 3; k++) img.push_back($urandom);
    load_image(32'd3, 2, 10);

    // random image sizes
    for (int r = 0; r < 3; r++) begin
      do_reset();
      img.delete();
      n = int'($urandom_range(CAP, 1));
      for (int k = 0; k < n; k++) img.push_back($urandom);
      load_image(32'(n), 3, int'($urandom_range(3, 0)));
    end

    // reset mid-handshake drops tx_valid
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    check("ack_offered", 64'(tx_valid), 64'(1));
    do_reset();

    // reset after 2 bytes of word 1, then a one-word image
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h03 : 8'h00, 0);
    w = $urandom;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    do_reset();
    img.delete();
    img.push_back($urandom);
    load_image(32'd1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
